core_mem_sram_rsp: RTL and testbench

Responder-side endpoint for the core memory interface: it implements the RSP view of `core_mem_if` in front of an internal word-organised SRAM array. It is the memory model behind the instruction and data ports of the core in the integration testbench and on small FPGA builds. It also provides programmable grant wait states and address-range error responses.

---
 rtl/core_mem_sram_rsp.sv | 137 +++++++++++++
 tb/tb_core_mem_sram_rsp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_sram_rsp.sv
// core_mem_sram_rsp: responder endpoint of the core memory interface backed by
// a word-organised 64-bit SRAM array with programmable grant wait states.
// Optional feature: define CORE_MEM_SRAM_RSP_ERR_EN to enable address-range
// checking with error responses; otherwise addresses alias modulo the array.
module core_mem_sram_rsp #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [63:0] BASE        = 64'h0000_0000_8000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [63:0]   mem_q [DEPTH];

  logic [63:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          wr_en;
  logic [63:0]   wr_word;

  // Grant once the request has been held for the programmed number of cycles;
  // reset forces it low immediately so no array access can slip through.
  assign mem_gnt   = mem_req && (cnt_q == WAIT_LIM) && !g_reset;
  assign accept    = mem_gnt;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

  // Address decode: word index relative to BASE, plus the range check when enabled.
  always_comb begin
    off = mem_addr - BASE;
    idx = off[3 +: AW];
`ifdef CORE_MEM_SRAM_RSP_ERR_EN
    in_range = (mem_addr >= BASE) && (off < SPAN);
`else
    in_range = 1'b1;
`endif
  end

`ifndef CORE_MEM_SRAM_RSP_ERR_EN
  // Without range checking only the index bits of the offset matter.
  logic unused_off;
  assign unused_off = ^{off[63:AW+3], off[2:0]};
`endif

  // Wait counter and two-state FSM tracking an outstanding request.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!mem_req || mem_gnt) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (mem_req && HAS_WAIT) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_gnt || !mem_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response and write-merge: reads load rdata, writes merge strobed lanes,
  // out-of-range accepts report an error with zero data.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_word[8*i +: 8] = mem_strb[i] ? mem_wdata[8*i +: 8] : mem_q[idx][8*i +: 8];
    end
    if (accept) begin
      err_d = !in_range;
      if (!in_range) begin
        rdata_d = 64'd0;
      end else if (mem_wen) begin
        wr_en = 1'b1;
      end else begin
        rdata_d = mem_q[idx];
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      mem_q[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_core_mem_sram_rsp.sv
// Directed testbench for core_mem_sram_rsp with three instances using
// WAIT_CYCLES of 0, 2 and 3. Honors CORE_MEM_SRAM_RSP_ERR_EN when defined.
module tb_core_mem_sram_rsp;

  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic [63:0] addr  [3];
  logic        wen   [3];
  logic [7:0]  strb  [3];
  logic [63:0] wdata [3];
  logic        gnt   [3];
  logic        err   [3];
  logic [63:0] rdata [3];

  int checks;
  int failures;

  core_mem_sram_rsp #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) dut_w0 (
    .g_clk(clk), .g_reset(rst), .mem_req(req[0]), .mem_addr(addr[0]), .mem_wen(wen[0]),
    .mem_strb(strb[0]), .mem_wdata(wdata[0]), .mem_gnt(gnt[0]), .mem_err(err[0]),
    .mem_rdata(rdata[0]));

  core_mem_sram_rsp #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(2)) dut_w2 (
    .g_clk(clk), .g_reset(rst), .mem_req(req[1]), .mem_addr(addr[1]), .mem_wen(wen[1]),
    .mem_strb(strb[1]), .mem_wdata(wdata[1]), .mem_gnt(gnt[1]), .mem_err(err[1]),
    .mem_rdata(rdata[1]));

  core_mem_sram_rsp #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(3)) dut_w3 (
    .g_clk(clk), .g_reset(rst), .mem_req(req[2]), .mem_addr(addr[2]), .mem_wen(wen[2]),
    .mem_strb(strb[2]), .mem_wdata(wdata[2]), .mem_gnt(gnt[2]), .mem_err(err[2]),
    .mem_rdata(rdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on instance k starting at a falling edge; returns after the
  // falling edge following acceptance with req still high.
  task automatic do_req(input int k, input logic [63:0] a, input logic w, input logic [7:0] s,
                        input logic [63:0] d, output int waited, output bit granted);
    req[k] = 1'b1; addr[k] = a; wen[k] = w; strb[k] = s; wdata[k] = d;
    waited = 0; granted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (gnt[k] === 1'b1) begin
        granted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; wen[k] = 1'b0; strb[k] = 8'h00;
  endtask

  task automatic test_reset;
    req[0] = 1'b1; addr[0] = BASE; wen[0] = 1'b0; strb[0] = 8'h00; wdata[0] = 64'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0", gnt[0]); end
    checks++;
    if (rdata[0] !== 64'd0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata[0]); end
    checks++;
    if (err[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err[0]); end
    rst = 1'b0;
    #1;
    checks++;
    if (gnt[0] !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_gnt got=%b exp=1", gnt[0]); end
    @(negedge clk);
    idle(0);
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    int w; bit g;
    do_req(2, BASE + 64'd8, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, w, g);
    checks++;
    if (!g || w != 3) begin failures++; $display("[TB] FAIL wait3_write_latency got=%0d granted=%0d exp=3", w, g); end
    checks++;
    if (rdata[2] !== 64'd0) begin failures++; $display("[TB] FAIL wait3_write_keeps_rdata got=%h exp=0", rdata[2]); end
    do_req(2, BASE + 64'd8, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (!g || w != 3) begin failures++; $display("[TB] FAIL wait3_read_latency got=%0d granted=%0d exp=3", w, g); end
    checks++;
    if (rdata[2] !== 64'h1122_3344_5566_7788) begin
      failures++; $display("[TB] FAIL wait3_read_data got=%h exp=1122334455667788", rdata[2]);
    end
    checks++;
    if (err[2] !== 1'b0) begin failures++; $display("[TB] FAIL wait3_read_err got=%b exp=0", err[2]); end
    idle(2);
    @(negedge clk);
  endtask

  task automatic test_strobes;
    int w; bit g;
    do_req(0, BASE + 64'd16, 1'b1, 8'hFF, 64'd0, w, g);
    checks++;
    if (!g || w != 0) begin failures++; $display("[TB] FAIL w0_latency got=%0d granted=%0d exp=0", w, g); end
    do_req(0, BASE + 64'd16, 1'b1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, w, g);
    do_req(0, BASE + 64'd16, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (rdata[0] !== 64'h0000_0000_FFFF_FFFF) begin
      failures++; $display("[TB] FAIL strb_low_half got=%h exp=00000000ffffffff", rdata[0]);
    end
    do_req(0, BASE + 64'd16, 1'b1, 8'h00, 64'h1234_5678_9ABC_DEF0, w, g);
    do_req(0, BASE + 64'd16, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (rdata[0] !== 64'h0000_0000_FFFF_FFFF) begin
      failures++; $display("[TB] FAIL strb_zero_noop got=%h exp=00000000ffffffff", rdata[0]);
    end
    do_req(0, BASE + 64'd16 + 64'd5, 1'b1, 8'h81, 64'hAB11_2233_4455_66CD, w, g);
    do_req(0, BASE + 64'd16, 1'b0, 8'hFF, 64'd0, w, g);
    checks++;
    if (rdata[0] !== 64'hAB00_0000_FFFF_FFCD) begin
      failures++; $display("[TB] FAIL strb_edge_lanes got=%h exp=ab000000ffffffcd", rdata[0]);
    end
    idle(0);
    @(negedge clk);
  endtask

  task automatic test_range;
    int w; bit g;
`ifdef CORE_MEM_SRAM_RSP_ERR_EN
    do_req(0, BASE, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, w, g);
    do_req(0, BASE + SPAN, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, w, g);
    checks++;
    if (err[0] !== 1'b1 || rdata[0] !== 64'd0) begin
      failures++; $display("[TB] FAIL oor_write got err=%b rdata=%h exp err=1 rdata=0", err[0], rdata[0]);
    end
    do_req(0, BASE, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (err[0] !== 1'b0 || rdata[0] !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("[TB] FAIL word0_intact got err=%b rdata=%h exp err=0 rdata=0123456789abcdef", err[0], rdata[0]);
    end
    do_req(0, BASE - 64'd8, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (err[0] !== 1'b1 || rdata[0] !== 64'd0) begin
      failures++; $display("[TB] FAIL oor_read_below got err=%b rdata=%h exp err=1 rdata=0", err[0], rdata[0]);
    end
`else
    do_req(0, BASE + SPAN, 1'b1, 8'hFF, 64'h0000_0000_0000_00A5, w, g);
    checks++;
    if (err[0] !== 1'b0) begin failures++; $display("[TB] FAIL alias_write_err got=%b exp=0", err[0]); end
    do_req(0, BASE, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (err[0] !== 1'b0 || rdata[0] !== 64'h0000_0000_0000_00A5) begin
      failures++; $display("[TB] FAIL alias_read got err=%b rdata=%h exp err=0 rdata=a5", err[0], rdata[0]);
    end
`endif
    idle(0);
    @(negedge clk);
  endtask

  task automatic test_abort_reset;
    int w; bit g;
    req[1] = 1'b1; addr[1] = BASE + 64'd24; wen[1] = 1'b1; strb[1] = 8'hFF; wdata[1] = 64'h55;
    @(negedge clk);
    checks++;
    if (gnt[1] !== 1'b0) begin failures++; $display("[TB] FAIL abort_early_gnt got=%b exp=0", gnt[1]); end
    idle(1);
    @(negedge clk);
    checks++;
    if (gnt[1] !== 1'b0) begin failures++; $display("[TB] FAIL abort_dropped_gnt got=%b exp=0", gnt[1]); end
    do_req(1, BASE + 64'd24, 1'b1, 8'hFF, 64'h55, w, g);
    checks++;
    if (!g || w != 2) begin failures++; $display("[TB] FAIL reraise_latency got=%0d granted=%0d exp=2", w, g); end
    do_req(1, BASE + 64'd24, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (!g || w != 2 || rdata[1] !== 64'h55) begin
      failures++; $display("[TB] FAIL w2_read got lat=%0d rdata=%h exp lat=2 rdata=55", w, rdata[1]);
    end
    req[1] = 1'b1; addr[1] = BASE + 64'd24; wen[1] = 1'b1; strb[1] = 8'hFF; wdata[1] = 64'hBB;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (gnt[1] !== 1'b0 || rdata[1] !== 64'd0 || err[1] !== 1'b0) begin
      failures++; $display("[TB] FAIL midwait_reset got gnt=%b rdata=%h err=%b exp 0/0/0", gnt[1], rdata[1], err[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    do_req(1, BASE + 64'd24, 1'b1, 8'hFF, 64'hBB, w, g);
    checks++;
    if (!g || w != 2) begin failures++; $display("[TB] FAIL post_reset_latency got=%0d granted=%0d exp=2", w, g); end
    do_req(1, BASE + 64'd24, 1'b0, 8'h00, 64'd0, w, g);
    checks++;
    if (rdata[1] !== 64'hBB) begin failures++; $display("[TB] FAIL post_reset_read got=%h exp=bb", rdata[1]); end
    idle(1);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; addr[k] = BASE; wen[k] = 1'b0; strb[k] = 8'h00; wdata[k] = 64'd0;
    end
    test_reset();
    test_wait_states();
    test_strobes();
    test_range();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
